// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: CTRL_COUNT read/write control registers
// followed by STAT_COUNT read-only status words in the address map.
// Write and read paths are independent; each handles one outstanding
// transaction. Per-register pulses support trigger-on-write and
// clear-on-read behaviour in the user logic.
module axi_lite_regbank #(
  parameter int              DATA_W     = 32,
  parameter int              ADDR_W     = 12,
  parameter int              CTRL_COUNT = 16,
  parameter int              STAT_COUNT = 16,
  parameter logic [DATA_W-1:0] CTRL_RESET = '0
) (
  input  logic                         AXI_ACLK,
  input  logic                         AXI_ARESET,
  input  logic [ADDR_W-1:0]            AXI_AWADDR,
  input  logic                         AXI_AWVALID,
  output logic                         AXI_AWREADY,
  input  logic [DATA_W-1:0]            AXI_WDATA,
  input  logic [DATA_W/8-1:0]          AXI_WSTRB,
  input  logic                         AXI_WVALID,
  output logic                         AXI_WREADY,
  output logic [1:0]                   AXI_BRESP,
  output logic                         AXI_BVALID,
  input  logic                         AXI_BREADY,
  input  logic [ADDR_W-1:0]            AXI_ARADDR,
  input  logic                         AXI_ARVALID,
  output logic                         AXI_ARREADY,
  output logic [DATA_W-1:0]            AXI_RDATA,
  output logic [1:0]                   AXI_RRESP,
  output logic                         AXI_RVALID,
  input  logic                         AXI_RREADY,
  output logic [CTRL_COUNT*DATA_W-1:0] ctrl_regs,
  output logic [CTRL_COUNT-1:0]        ctrl_wr_pulse,
  input  logic [STAT_COUNT*DATA_W-1:0] stat_regs,
  output logic [STAT_COUNT-1:0]        stat_rd_pulse
);
  localparam int          STRB_W   = DATA_W / 8;
  localparam int          ADDR_LSB = $clog2(STRB_W);
  localparam int          IDX_W    = ADDR_W - ADDR_LSB;
  localparam int unsigned CTRL_N   = CTRL_COUNT;
  localparam int unsigned STAT_N   = STAT_COUNT;
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;

  logic                         started;
  logic                         aw_open, w_open, ar_open;
  logic                         aw_held, w_held;
  logic [IDX_W-1:0]             aw_idx_q;
  logic [DATA_W-1:0]            wdata_q;
  logic [STRB_W-1:0]            wstrb_q;
  logic [CTRL_COUNT*DATA_W-1:0] ctrl_q;
  logic                         bvalid, rvalid;
  logic [1:0]                   bresp, rresp;
  logic [DATA_W-1:0]            rdata;

  logic                         aw_hs, w_hs, ar_hs, commit, wr_ctrl;
  logic [IDX_W-1:0]             wr_idx;
  logic [31:0]                  wr_idx32, rd_idx32;
  logic [DATA_W-1:0]            wr_data, rd_word;
  logic [STRB_W-1:0]            wr_strb;
  logic                         rd_err;
  logic [STAT_COUNT-1:0]        rd_stat_hit;
  logic                         unused_addr_lsbs;

  assign unused_addr_lsbs = ^{AXI_AWADDR[ADDR_LSB-1:0], AXI_ARADDR[ADDR_LSB-1:0]};

  // Handshakes and commit: a held half combines with a live half arriving this edge.
  assign aw_hs    = AXI_AWVALID & aw_open;
  assign w_hs     = AXI_WVALID & w_open;
  assign ar_hs    = AXI_ARVALID & ar_open;
  assign commit   = (aw_hs | aw_held) & (w_hs | w_held);
  assign wr_idx   = aw_hs ? AXI_AWADDR[ADDR_W-1:ADDR_LSB] : aw_idx_q;
  assign wr_data  = w_hs ? AXI_WDATA : wdata_q;
  assign wr_strb  = w_hs ? AXI_WSTRB : wstrb_q;
  assign wr_idx32 = 32'(wr_idx);
  assign rd_idx32 = 32'(AXI_ARADDR[ADDR_W-1:ADDR_LSB]);
  assign wr_ctrl  = wr_idx32 < CTRL_N;

  // Write channel: capture each half, commit when both are in, hold B until accepted.
  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      started  <= 1'b0;
      aw_open  <= 1'b0;
      w_open   <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid   <= 1'b0;
      bresp    <= OKAY;
    end else if (!started) begin
      started <= 1'b1;
      aw_open <= 1'b1;
      w_open  <= 1'b1;
    end else begin
      if (aw_hs) begin
        aw_open  <= 1'b0;
        aw_idx_q <= AXI_AWADDR[ADDR_W-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_open  <= 1'b0;
        wdata_q <= AXI_WDATA;
        wstrb_q <= AXI_WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_ctrl ? OKAY : SLVERR;
      end else begin
        if (aw_hs) aw_held <= 1'b1;
        if (w_hs)  w_held  <= 1'b1;
      end
      if (bvalid && AXI_BREADY) begin
        bvalid  <= 1'b0;
        aw_open <= 1'b1;
        w_open  <= 1'b1;
      end
    end
  end

  // Control registers: byte-strobed update at commit plus a one-cycle write pulse.
  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      ctrl_q        <= {CTRL_COUNT{CTRL_RESET}};
      ctrl_wr_pulse <= '0;
    end else begin
      for (int unsigned i = 0; i < CTRL_N; i++) begin
        ctrl_wr_pulse[i] <= commit && (wr_idx32 == i);
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (commit && (wr_idx32 == i) && wr_strb[b])
            ctrl_q[i*DATA_W + 8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read decode: control word, sampled status word, or zero with an error flag.
  always_comb begin
    rd_word     = '0;
    rd_err      = 1'b1;
    rd_stat_hit = '0;
    for (int unsigned i = 0; i < CTRL_N; i++) begin
      if (rd_idx32 == i) begin
        rd_word = ctrl_q[i*DATA_W +: DATA_W];
        rd_err  = 1'b0;
      end
    end
    for (int unsigned j = 0; j < STAT_N; j++) begin
      if (rd_idx32 == CTRL_N + j) begin
        rd_word        = stat_regs[j*DATA_W +: DATA_W];
        rd_err         = 1'b0;
        rd_stat_hit[j] = 1'b1;
      end
    end
  end

  // Read channel: load R on the AR edge, hold until accepted, then reopen AR.
  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      ar_open       <= 1'b0;
      rvalid        <= 1'b0;
      rresp         <= OKAY;
      rdata         <= '0;
      stat_rd_pulse <= '0;
    end else begin
      stat_rd_pulse <= '0;
      if (!started) begin
        ar_open <= 1'b1;
      end else if (ar_hs) begin
        ar_open       <= 1'b0;
        rvalid        <= 1'b1;
        rdata         <= rd_word;
        rresp         <= rd_err ? SLVERR : OKAY;
        stat_rd_pulse <= rd_stat_hit;
      end else if (rvalid && AXI_RREADY) begin
        rvalid  <= 1'b0;
        ar_open <= 1'b1;
      end
    end
  end

  assign AXI_AWREADY = aw_open;
  assign AXI_WREADY  = w_open;
  assign AXI_BVALID  = bvalid;
  assign AXI_BRESP   = bresp;
  assign AXI_ARREADY = ar_open;
  assign AXI_RVALID  = rvalid;
  assign AXI_RRESP   = rresp;
  assign AXI_RDATA   = rdata;
  assign ctrl_regs   = ctrl_q;

endmodule
